// File: rtl/type_override_pkg.sv
// Shared types and defaults for the type override resolver.
package type_override_pkg;

  localparam int unsigned IdW      = 6;
  localparam int unsigned MaxDepth = 4;

  // Entry layout at the default id width.
  typedef struct packed {
    logic           valid;
    logic [IdW-1:0] target;
  } ovr_entry_t;

  typedef enum logic [1:0] {
    StIdle,
    StWalk,
    StDone
  } resolver_state_e;

endpackage

// File: rtl/type_override_table.sv
// Override table: one entry per type id, synchronous write, combinational read.
module type_override_table
  import type_override_pkg::*;
#(
  parameter int unsigned ID_W = IdW
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            we_i,
  input  logic [ID_W-1:0] wr_id_i,
  input  logic            wr_set_i,
  input  logic [ID_W-1:0] wr_target_i,
  input  logic [ID_W-1:0] rd_id_i,
  output logic            rd_valid_o,
  output logic [ID_W-1:0] rd_target_o
);

  localparam int unsigned Entries = 2 ** ID_W;

  logic [Entries-1:0] valid_q;
  logic [ID_W-1:0]    target_q [Entries];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
    end else if (we_i) begin
      valid_q[wr_id_i] <= wr_set_i;
    end
  end

  // Targets are only meaningful behind a valid bit, so they need no reset.
  always_ff @(posedge clk_i) begin
    if (we_i && wr_set_i) begin
      target_q[wr_id_i] <= wr_target_i;
    end
  end

  assign rd_valid_o  = valid_q[rd_id_i];
  assign rd_target_o = target_q[rd_id_i];

endmodule

// File: rtl/type_override_resolver.sv
// Follows override chains to the final type id; optional counters under TYPE_OVERRIDE_STATS_EN.
module type_override_resolver
  import type_override_pkg::*;
#(
  parameter int unsigned ID_W      = IdW,
  parameter int unsigned MAX_DEPTH = MaxDepth,
  localparam int unsigned DW       = $clog2(MAX_DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cfg_we,
  input  logic [ID_W-1:0] cfg_id,
  input  logic            cfg_set,
  input  logic [ID_W-1:0] cfg_target,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [ID_W-1:0] req_id,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [ID_W-1:0] rsp_id,
  output logic [DW-1:0]   rsp_depth,
`ifdef TYPE_OVERRIDE_STATS_EN
  output logic [31:0]     stat_lookups,
  output logic [31:0]     stat_overridden,
  output logic [31:0]     stat_errors,
`endif
  output logic            rsp_err
);

  localparam logic [DW-1:0] DepthLimit = DW'(MAX_DEPTH);

  resolver_state_e state_q, state_d;
  logic [ID_W-1:0] cur_q, cur_d;
  logic [ID_W-1:0] orig_q, orig_d;
  logic [DW-1:0]   depth_q, depth_d;
  logic [ID_W-1:0] rsp_id_q, rsp_id_d;
  logic [DW-1:0]   rsp_depth_q, rsp_depth_d;
  logic            rsp_err_q, rsp_err_d;

  logic            rd_valid;
  logic [ID_W-1:0] rd_target;

  type_override_table #(
    .ID_W(ID_W)
  ) u_table (
    .clk_i      (clk),
    .rst_i      (rst),
    .we_i       (cfg_we),
    .wr_id_i    (cfg_id),
    .wr_set_i   (cfg_set),
    .wr_target_i(cfg_target),
    .rd_id_i    (cur_q),
    .rd_valid_o (rd_valid),
    .rd_target_o(rd_target)
  );

  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    orig_d      = orig_q;
    depth_d     = depth_q;
    rsp_id_d    = rsp_id_q;
    rsp_depth_d = rsp_depth_q;
    rsp_err_d   = rsp_err_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          orig_d  = req_id;
          cur_d   = req_id;
          depth_d = '0;
          state_d = StWalk;
        end
      end
      StWalk: begin
        if (!rd_valid) begin
          rsp_id_d    = cur_q;
          rsp_depth_d = depth_q;
          rsp_err_d   = 1'b0;
          state_d     = StDone;
        end else if (depth_q < DepthLimit) begin
          cur_d   = rd_target;
          depth_d = depth_q + DW'(1);
        end else begin
          // Cycle or over-deep chain: hand back the original id.
          rsp_id_d    = orig_q;
          rsp_depth_d = DepthLimit;
          rsp_err_d   = 1'b1;
          state_d     = StDone;
        end
      end
      StDone: begin
        if (rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cur_q       <= '0;
      orig_q      <= '0;
      depth_q     <= '0;
      rsp_id_q    <= '0;
      rsp_depth_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      orig_q      <= orig_d;
      depth_q     <= depth_d;
      rsp_id_q    <= rsp_id_d;
      rsp_depth_q <= rsp_depth_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign req_ready = (state_q == StIdle) && !rst;
  assign rsp_valid = (state_q == StDone);
  assign rsp_id    = rsp_id_q;
  assign rsp_depth = rsp_depth_q;
  assign rsp_err   = rsp_err_q;

`ifdef TYPE_OVERRIDE_STATS_EN
  logic        rsp_hs;
  logic [31:0] lookups_q, overridden_q, errors_q;

  assign rsp_hs = rsp_valid && rsp_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      lookups_q    <= '0;
      overridden_q <= '0;
      errors_q     <= '0;
    end else if (rsp_hs) begin
      if (lookups_q != '1) lookups_q <= lookups_q + 32'd1;
      if ((rsp_depth_q != '0) && !rsp_err_q && (overridden_q != '1)) begin
        overridden_q <= overridden_q + 32'd1;
      end
      if (rsp_err_q && (errors_q != '1)) errors_q <= errors_q + 32'd1;
    end
  end

  assign stat_lookups    = lookups_q;
  assign stat_overridden = overridden_q;
  assign stat_errors     = errors_q;
`endif

endmodule

// File: tb/tb_type_override_resolver.sv
// Randomised and directed checks of type_override_resolver against a chain-walking model.
module tb_type_override_resolver;

  localparam int ID_W      = 6;
  localparam int MAX_DEPTH = 4;
  localparam int DW        = $clog2(MAX_DEPTH + 1);
  localparam int N         = 2 ** ID_W;

  logic            clk;
  logic            rst;
  logic            cfg_we;
  logic [ID_W-1:0] cfg_id;
  logic            cfg_set;
  logic [ID_W-1:0] cfg_target;
  logic            req_valid;
  logic            req_ready;
  logic [ID_W-1:0] req_id;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [ID_W-1:0] rsp_id;
  logic [DW-1:0]   rsp_depth;
  logic            rsp_err;
`ifdef TYPE_OVERRIDE_STATS_EN
  logic [31:0]     stat_lookups, stat_overridden, stat_errors;
  int              m_lookups, m_overridden, m_errors;
`endif

  type_override_resolver #(
    .ID_W     (ID_W),
    .MAX_DEPTH(MAX_DEPTH)
  ) dut (
`ifdef TYPE_OVERRIDE_STATS_EN
    .stat_lookups   (stat_lookups),
    .stat_overridden(stat_overridden),
    .stat_errors    (stat_errors),
`endif
    .clk       (clk),
    .rst       (rst),
    .cfg_we    (cfg_we),
    .cfg_id    (cfg_id),
    .cfg_set   (cfg_set),
    .cfg_target(cfg_target),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_id    (req_id),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_depth (rsp_depth),
    .rsp_err   (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference table: which ids are overridden and to what.
  bit mv [N];
  int mt [N];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic void resolve(input int id, output int rid, output int rdep, output bit rerr);
    int cur = id;
    int d = 0;
    rerr = 1'b0;
    forever begin
      if (!mv[cur]) begin
        rid = cur; rdep = d; return;
      end
      if (d == MAX_DEPTH) begin
        rid = id; rdep = MAX_DEPTH; rerr = 1'b1; return;
      end
      cur = mt[cur];
      d++;
    end
  endfunction

  task automatic cfg_write(input int id, input bit set, input int tgt);
    @(negedge clk);
    cfg_we = 1'b1; cfg_id = ID_W'(id); cfg_set = set; cfg_target = ID_W'(tgt);
    @(negedge clk);
    cfg_we = 1'b0;
    mv[id] = set;
    if (set) mt[id] = tgt;
  endtask

  // One full transaction; optionally plants a config write at wait cycle wr_at.
  task automatic do_req(input int id, input int hold, input int wr_at,
                        input int wr_id, input int wr_tgt);
    int eid, edep, lat;
    bit eerr;
    resolve(id, eid, edep, eerr);
    @(negedge clk);
    check("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_id = ID_W'(id);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      if (lat == wr_at) begin
        cfg_we = 1'b1; cfg_id = ID_W'(wr_id); cfg_set = 1'b1; cfg_target = ID_W'(wr_tgt);
      end
      @(negedge clk);
      cfg_we = 1'b0;
      lat++;
    end
    if (wr_at >= 0) begin
      mv[wr_id] = 1'b1; mt[wr_id] = wr_tgt;
    end
    check("rsp_timeout", 32'(lat < 20), 32'd1);
    check("rsp_latency", 32'(lat), 32'(eerr ? MAX_DEPTH + 1 : edep + 1));
    check("rsp_id", 32'(rsp_id), 32'(eid));
    check("rsp_depth", 32'(rsp_depth), 32'(edep));
    check("rsp_err", 32'(rsp_err), 32'(eerr));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", 32'(rsp_valid), 32'd1);
      check("hold_id", 32'(rsp_id), 32'(eid));
      check("hold_depth", 32'(rsp_depth), 32'(edep));
      check("hold_req_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("req_ready_after", 32'(req_ready), 32'd1);
    check("rsp_valid_after", 32'(rsp_valid), 32'd0);
`ifdef TYPE_OVERRIDE_STATS_EN
    m_lookups++;
    if (edep > 0 && !eerr) m_overridden++;
    if (eerr) m_errors++;
`endif
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_id", 32'(rsp_id), 32'd0);
    check("rst_rsp_depth", 32'(rsp_depth), 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < N; i++) mv[i] = 1'b0;
`ifdef TYPE_OVERRIDE_STATS_EN
    check("rst_stat_lookups", stat_lookups, 32'd0);
    check("rst_stat_overridden", stat_overridden, 32'd0);
    check("rst_stat_errors", stat_errors, 32'd0);
    m_lookups = 0; m_overridden = 0; m_errors = 0;
`endif
    @(negedge clk);
    check("post_rst_req_ready", 32'(req_ready), 32'd1);
  endtask

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_id = '0; cfg_set = 1'b0; cfg_target = '0;
    req_valid = 1'b0; req_id = '0; rsp_ready = 1'b0;
    for (int i = 0; i < N; i++) begin
      mv[i] = 1'b0; mt[i] = 0;
    end
    apply_reset();

    // Empty table, then a two-hop chain, then a shortened chain.
    do_req(5, 0, -1, 0, 0);
    cfg_write(3, 1'b1, 7);
    cfg_write(7, 1'b1, 9);
    do_req(3, 0, -1, 0, 0);
    cfg_write(7, 1'b0, 0);
    do_req(3, 0, -1, 0, 0);

    // Two-element cycle hits the depth limit.
    cfg_write(2, 1'b1, 4);
    cfg_write(4, 1'b1, 2);
    do_req(2, 0, -1, 0, 0);

    // Self-override with a long stall in DONE.
    cfg_write(20, 1'b1, 20);
    do_req(20, 10, -1, 0, 0);

    // Entry 9 written on the very cycle the walk reads it: old value wins.
    cfg_write(7, 1'b1, 9);
    do_req(3, 0, 2, 9, 11);
    check("race_old_value", 32'(rsp_id), 32'd9);
    do_req(3, 0, -1, 0, 0);
    check("race_new_value", 32'(rsp_id), 32'd11);

    // Randomised chains over a small id range so cycles and deep chains occur.
    for (int n = 0; n < 60; n++) begin
      int nw = $urandom_range(0, 2);
      for (int w = 0; w < nw; w++) begin
        cfg_write($urandom_range(0, 7), ($urandom_range(0, 3) != 0), $urandom_range(0, 7));
      end
      do_req($urandom_range(0, 8), $urandom_range(0, 2), -1, 0, 0);
    end

`ifdef TYPE_OVERRIDE_STATS_EN
    check("stat_lookups", stat_lookups, 32'(m_lookups));
    check("stat_overridden", stat_overridden, 32'(m_overridden));
    check("stat_errors", stat_errors, 32'(m_errors));
`endif

    // Reset in the middle of a walk discards it and clears the table.
    cfg_write(3, 1'b1, 7);
    cfg_write(7, 1'b1, 9);
    cfg_write(9, 1'b1, 11);
    @(negedge clk);
    req_valid = 1'b1; req_id = ID_W'(3);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    apply_reset();
    do_req(3, 0, -1, 0, 0);
    check("post_rst_id", 32'(rsp_id), 32'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/type_override_resolver.md
# type_override_resolver

Resolves a requested type id to its final override type id before it reaches the type factory's creation stage. Holds a programmable override table (one entry per type id) and follows override chains hop by hop, with a bounded depth to catch cycles. Sits directly upstream of the factory: consumes create requests and produces resolved requests carrying the type id the factory must actually build.

## Interface
Parameters:
- `ID_W`, 6: type id width; the table has 2**ID_W entries.
- `MAX_DEPTH`, 4: maximum override hops before the block flags an error; must be ≥1.

Ports:
- `clk`  in  1  clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cfg_we`  in  1  table write strobe.
- `cfg_id`  in  ID_W  entry to write.
- `cfg_set`  in  1  1: install the override `cfg_id -> cfg_target`; 0: clear the entry.
- `cfg_target`  in  ID_W  override target type id.
- `req_valid`  in  1  create request valid.
- `req_ready`  out  1  block can accept a request.
- `req_id`  in  ID_W  requested type id.
- `rsp_valid`  out  1  resolved request valid.
- `rsp_ready`  in  1  downstream factory accepts.
- `rsp_id`  out  ID_W  resolved type id.
- `rsp_depth`  out  $clog2(MAX_DEPTH+1)  number of hops taken.
- `rsp_err`  out  1  chain exceeded MAX_DEPTH (cycle or over-deep chain).

## Operation
- States: IDLE, WALK, DONE.
- `req_ready` = (state==IDLE) && !rst.
- IDLE: on `req_valid && req_ready`, latch `orig=req_id`, `cur=req_id`, `depth=0`, go to WALK.
- WALK, once per cycle, reading entry[cur]:
  - entry invalid: `rsp_id=cur`, `rsp_depth=depth`, `rsp_err=0`, go to DONE.
  - entry valid, depth<MAX_DEPTH: `cur=target`, `depth=depth+1`, stay.
  - entry valid, depth==MAX_DEPTH: `rsp_id=orig`, `rsp_depth=MAX_DEPTH`, `rsp_err=1`, go to DONE.
- A self-override (target==id) is not special-cased; it hits the depth limit and errors.
- DONE: `rsp_valid=1`; `rsp_id`, `rsp_depth` and `rsp_err` stay stable until `rsp_ready`; on handshake go to IDLE.
- Config writes are accepted in any state. A walk that reads an entry in the same cycle it is written sees the old value; the new value applies from the next cycle.
- Reset: all table entries invalid, state IDLE. `rsp_valid`, `rsp_id`, `rsp_depth` and `rsp_err` are all 0. An in-flight walk or an unaccepted response is discarded. `req_ready` is 0 while `rst` is high and 1 on the first cycle after.

## Timing
- Request accepted at edge N with d hops (d≤MAX_DEPTH, no error): `rsp_valid` is high after edge N+1+d.
- Error case: `rsp_valid` is high after edge N+1+MAX_DEPTH.
- `rsp_valid` held with `rsp_ready` low: the block stalls indefinitely in DONE, and `req_ready` stays 0.
- Throughput: at most one request per d+3 cycles. There is no overlap and no combinational path from `req_*` to `rsp_*`.

## Configuration
- `TYPE_OVERRIDE_STATS_EN` defined: adds outputs `stat_lookups`, `stat_overridden` and `stat_errors`, each 32 bits.
  - Each counter increments on the response handshake: lookups always; overridden when `rsp_depth>0 && !rsp_err`; errors when `rsp_err`.
  - All three saturate at all-ones and are cleared by `rst`.
- Not defined: ports and counters are absent; the rest of the behaviour is identical.

## Structure
- Package `type_override_pkg`:
  - default `ID_W` and `MAX_DEPTH` constants;
  - `ovr_entry_t` struct {valid, target};
  - `resolver_state_e` enum {IDLE, WALK, DONE}.
- Sub-module `type_override_table`:
  - 2**ID_W entries of `ovr_entry_t`;
  - one synchronous write port and one combinational read port;
  - reset clears every entry's valid bit.

## Test plan
- Empty table, `req_id`=5: `rsp_id`=5, `rsp_depth`=0, `rsp_err`=0, `rsp_valid` high 1 cycle after acceptance.
- Chain 3->7->9 installed, `req_id`=3: `rsp_id`=9, `rsp_depth`=2, `rsp_valid` 3 cycles after acceptance. Clear entry 7, then `req_id`=3: `rsp_id`=7, `rsp_depth`=1.
- Cycle 2->4->2, `req_id`=2, MAX_DEPTH=4: `rsp_err`=1, `rsp_id`=2, `rsp_depth`=4, response 5 cycles after acceptance.
- Hold `rsp_ready`=0 for 10 cycles: `rsp_valid`, `rsp_id` and `rsp_depth` stay stable and `req_ready`=0 throughout. Raise `rsp_ready`: `req_ready`=1 on the next cycle.
- Write entry 9->11 in the same cycle the walk of chain 3->7->9 reads entry 9: result `rsp_id`=9. The next request for 3 resolves to 11.
- Assert `rst` mid-walk: `rsp_valid`=0, table cleared. The next request for 3 returns `rsp_id`=3. With `TYPE_OVERRIDE_STATS_EN`, all counters read 0.
